// File: rtl/onchip_arb_pkg.sv
// Shared types for the two-port on-chip RAM arbiter.
//   arb_state_e       : arbiter operating state (scrub / run)
//   port_idx_t        : requester index (port 0 or port 1)
//   ONCHIP_ARB_NPORTS : number of requester ports
package onchip_arb_pkg;

  typedef enum logic [0:0] {
    ST_SCRUB = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  typedef logic [0:0] port_idx_t;

  localparam int unsigned ONCHIP_ARB_NPORTS = 2;

endpackage

// File: rtl/onchip_arb_rr2.sv
// Two-input round-robin grant logic with its last-grant history register.
//   clk, reset  : system clock, asynchronous active-high reset
//   i_en        : grants allowed this cycle
//   i_req       : per-port request vector
//   o_gnt       : a port is granted this cycle
//   o_gnt_idx   : index of the granted port (valid with o_gnt)
module onchip_arb_rr2
  import onchip_arb_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_en,
  input  logic [ONCHIP_ARB_NPORTS-1:0] i_req,
  output logic                         o_gnt,
  output port_idx_t                    o_gnt_idx
);

  port_idx_t r_last_grant;

  always_comb begin
    o_gnt = i_en & (|i_req);
    if (i_req[0] && i_req[1]) begin
      // Contention: the port that did not win most recently goes next.
      o_gnt_idx = ~r_last_grant;
    end else if (i_req[0]) begin
      o_gnt_idx = 1'b0;
    end else begin
      o_gnt_idx = 1'b1;
    end
  end

  // Resets to port 1 so port 0 wins the first contest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (o_gnt) begin
      r_last_grant <= o_gnt_idx;
    end
  end

endmodule

// File: rtl/nios_system_sdram_onchip_mem_arbiter.sv
// Round-robin arbiter sharing a single-port on-chip RAM (1-cycle read latency)
// between two Avalon-MM requesters. One access per cycle; read data is
// steered back with a per-port readdatavalid pulse.
//   m0_* / m1_* : Avalon-MM slave ports facing the two requesters
//   mem_*       : connection to the RAM s1 slave (mem_readdata is RAM q)
// Optional feature: define ONCHIP_ARB_SCRUB_EN to zero-fill the whole RAM
// after reset (2^ADDR_W cycles, both ports stalled) before normal operation.
module nios_system_sdram_onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  arb_state_e w_state;
  logic       w_en;
  logic       w_gnt;
  port_idx_t  w_gnt_idx;
  logic       w_sel_read;
  logic       w_sel_write;
  logic       r_rd_valid;
  port_idx_t  r_rd_owner;

`ifdef ONCHIP_ARB_SCRUB_EN
  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic [ADDR_W-1:0] r_scrub_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SCRUB;
      r_scrub_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_SCRUB) begin
        r_scrub_cnt <= r_scrub_cnt + ADDR_W'(1);
      end
    end
  end

  // Leave scrub right after the write to the last address.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_SCRUB && r_scrub_cnt == {ADDR_W{1'b1}}) begin
      w_state_next = ST_RUN;
    end
  end

  assign w_state = r_state;
`else
  assign w_state = ST_RUN;
`endif

  // No grants while reset is held, so waitrequest is high for both ports.
  assign w_en = ~reset & (w_state == ST_RUN);

  onchip_arb_rr2 u_rr2 (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_en),
    .i_req     ({m1_read | m1_write, m0_read | m0_write}),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign w_sel_read  = w_gnt_idx[0] ? m1_read  : m0_read;
  assign w_sel_write = w_gnt_idx[0] ? m1_write : m0_write;

  always_comb begin
    mem_address    = w_gnt_idx[0] ? m1_address    : m0_address;
    mem_byteenable = w_gnt_idx[0] ? m1_byteenable : m0_byteenable;
    mem_writedata  = w_gnt_idx[0] ? m1_writedata  : m0_writedata;
    mem_chipselect = w_gnt;
    mem_write      = w_gnt & w_sel_write;
`ifdef ONCHIP_ARB_SCRUB_EN
    if (!reset && r_state == ST_SCRUB) begin
      mem_address    = r_scrub_cnt;
      mem_byteenable = '1;
      mem_writedata  = '0;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end
`endif
  end

  assign mem_clken      = 1'b1;
  assign m0_waitrequest = ~(w_gnt & (w_gnt_idx == 1'b0));
  assign m1_waitrequest = ~(w_gnt & (w_gnt_idx == 1'b1));

  // Read-return pipeline: matches the RAM's one-cycle read latency.
  // Read+write together counts as a write, so it gets no response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_valid <= w_gnt & w_sel_read & ~w_sel_write;
      if (w_gnt) begin
        r_rd_owner <= w_gnt_idx;
      end
    end
  end

  assign m0_readdatavalid = r_rd_valid & (r_rd_owner == 1'b0);
  assign m1_readdatavalid = r_rd_valid & (r_rd_owner == 1'b1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: doc/nios_system_sdram_onchip_mem_arbiter.md
# nios_system_sdram_onchip_mem_arbiter

Two-port round-robin arbiter that shares the single-port 1024×32 on-chip RAM (registered address, unregistered q, 1-cycle read latency, byte-enabled writes) between two Avalon-MM requesters, e.g. the CPU data master and a DMA engine. It issues at most one access per cycle, steers readdata back to the owning port with a `readdatavalid` pulse, and optionally zero-fills the RAM after reset. It sits between the system interconnect and the RAM's s1 slave.

## Interface
- `ADDR_W`, 10: word address width; RAM depth is 2^ADDR_W.
- `DATA_W`, 32: data width; byteenable width is DATA_W/8.
- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mN_address`  in  ADDR_W  port N word address (N = 0, 1).
- `mN_byteenable`  in  DATA_W/8  port N byte lanes; used for writes only.
- `mN_read`  in  1  port N read request.
- `mN_write`  in  1  port N write request. read and write asserted together is illegal; treated as a write.
- `mN_writedata`  in  DATA_W  port N write data.
- `mN_waitrequest`  out  1  port N request not accepted this cycle.
- `mN_readdata`  out  DATA_W  port N read data; valid only with `mN_readdatavalid`.
- `mN_readdatavalid`  out  1  one-cycle pulse, read data for port N.
- `mem_address`  out  ADDR_W  to RAM address.
- `mem_byteenable`  out  DATA_W/8  to RAM byteenable.
- `mem_chipselect`  out  1  to RAM chipselect.
- `mem_write`  out  1  to RAM write.
- `mem_writedata`  out  DATA_W  to RAM writedata.
- `mem_clken`  out  1  to RAM clken; constant 1.
- `mem_readdata`  in  DATA_W  from RAM q.

## Operation
- States: `SCRUB` (present only with the macro) and `RUN`. Reset enters `SCRUB` if compiled in, otherwise `RUN`.
- A port requests when `read | write` is high. Requests are held stable by the master while `waitrequest` = 1 (Avalon rule).
- Arbitration in `RUN`, combinational within the cycle:
  - One requester: it is granted.
  - Both requesters: the port not granted most recently wins.
  - `last_grant` register updates only on a grant. Reset value is 1, so port 0 wins the first contest.
- Granted port: `waitrequest` = 0. `mem_*` is muxed from that port. `mem_chipselect` = 1, `mem_write` = its write.
- Losing or idle port: `waitrequest` = 1 whenever its request is present.
- No grant: `mem_chipselect` = 0, `mem_write` = 0. Address and data are don't-care.
- Read return:
  - A granted read sets `rd_valid_q` = 1 and `rd_owner_q` = the port for the next cycle.
  - `mN_readdatavalid` = `rd_valid_q & (rd_owner_q == N)`.
  - `mN_readdata` = `mem_readdata`, unregistered, for both ports.
- Writes have no response. Back-to-back grants are allowed every cycle, including a read to one port then a write from the other to the same address. Read-during-write returns old data (single-port RAM, data from previous cycle's access).
- Reset mid-operation: pending `readdatavalid` is dropped, `last_grant` returns to 1, and scrub restarts from address 0.

## Timing
- Reset values: `mN_waitrequest` = 1 while `reset` is high, `mN_readdatavalid` = 0, `mem_chipselect` = 0, `mem_write` = 0, `mem_clken` = 1, scrub counter = 0.
- Grant at cycle T: access is issued to the RAM at T; for reads, `readdatavalid` and data appear at T+1 (latency 1).
- Throughput: 1 access per cycle aggregate. Under continuous contention each port gets every other cycle.
- Worst-case wait for a continuously requesting port: 1 cycle in `RUN`.

## Configuration
- `ONCHIP_ARB_SCRUB_EN` defined:
  - After reset deasserts, `SCRUB` writes 0 to every address 0..2^ADDR_W−1 in ascending order, one per cycle, with byteenable all-ones.
  - Both ports see `waitrequest` = 1 throughout.
  - After the write to the last address (counter wrap), the block moves to `RUN` on the next cycle. Scrub takes exactly 2^ADDR_W cycles.
- Not defined: no `SCRUB` state and no counter; `RUN` from the first cycle after reset. RAM contents are those of its init file.

## Structure
- Shared package `onchip_arb_pkg`:
  - state enum {`ST_SCRUB`, `ST_RUN`}
  - port-index typedef (1 bit)
  - `ONCHIP_ARB_NPORTS` = 2
- One sub-module, `onchip_arb_rr2`: the 2-input round-robin grant logic plus the `last_grant` register.
- The top holds the muxes, the read-return pipeline register and the scrub FSM.

## Test plan
- Port 0 writes 0xDEADBEEF at address 5, then reads address 5 → `m0_waitrequest` = 0 on both; `m0_readdatavalid` exactly one cycle after the read grant with 0xDEADBEEF; `m1_readdatavalid` stays 0.
- Both ports read (addresses 1 and 2) continuously for 8 cycles → grants alternate 0,1,0,1…; each port gets 4 `readdatavalid` pulses with the correct data and owner.
- Port 1 writes 0x11223344 at address 7 with byteenable 4'b0101 over a pre-existing 0xFFFFFFFF → a port 0 read returns 0xFF22FF44.
- Reset asserted the cycle after a granted read → `readdatavalid` never pulses; after release, the first contest goes to port 0.
- With `ONCHIP_ARB_SCRUB_EN`, preload address 1023 with 0xA5A5A5A5, then reset → both `waitrequest` high for 1024 cycles; a subsequent read of 1023 returns 0.
- Without `ONCHIP_ARB_SCRUB_EN` → a port 0 read in the first cycle after reset is granted immediately.
